// File: rtl/fwd_scoreboard_if.sv
// ============================================================================
//  Module      : fwd_scoreboard_if
//  Description : Decode/execute-side bundle for the forwarding scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fwd_scoreboard_if #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int NRD    = 2,
    parameter int TW     = 2
);
    logic                      flush;
    logic                      issue_valid;
    logic [4:0]                issue_dst;
    logic [TW-1:0]             issue_tnew;
    logic [STAGES-1:0]         res_valid;
    logic [STAGES*WIDTH-1:0]   res_data;
    logic [NRD*5-1:0]          rd_addr;
    logic [NRD*TW-1:0]         rd_tuse;
    logic [NRD*WIDTH-1:0]      rf_data;
    logic [NRD*WIDTH-1:0]      rd_data;
    logic [NRD-1:0]            rd_hit;
    logic                      stall;

    modport master (
        output flush, issue_valid, issue_dst, issue_tnew, res_valid, res_data,
               rd_addr, rd_tuse, rf_data,
        input  rd_data, rd_hit, stall
    );

    modport slave (
        input  flush, issue_valid, issue_dst, issue_tnew, res_valid, res_data,
               rd_addr, rd_tuse, rf_data,
        output rd_data, rd_hit, stall
    );
endinterface

`default_nettype wire

// File: rtl/fwd_scoreboard.sv
// ============================================================================
//  Module      : fwd_scoreboard
//  Description : Tracks in-flight register writes after decode; forwards
//                operands to the decode read ports and raises load-use stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_scoreboard #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int NRD    = 2,
    parameter int TW     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    fwd_scoreboard_if.slave      sb
);

    localparam logic [TW-1:0] c_TNEW_ONE = {{(TW-1){1'b0}}, 1'b1};

    function automatic logic [TW-1:0] satDec(input logic [TW-1:0] x);
        return (x == '0) ? '0 : x - c_TNEW_ONE;
    endfunction

    logic                 r_v    [STAGES];
    logic                 r_ok   [STAGES];
    logic [4:0]           r_dst  [STAGES];
    logic [TW-1:0]        r_tnew [STAGES];
    logic [WIDTH-1:0]     r_data [STAGES];

    logic                 w_okEff   [STAGES];
    logic [WIDTH-1:0]     w_dataEff [STAGES];
    logic [NRD*WIDTH-1:0] w_rdData;
    logic [NRD-1:0]       w_rdHit;
    logic [NRD-1:0]       w_found;
    logic                 w_stall;
    logic                 w_accept;

    // A result strobe on an empty slot must not disturb or forward anything.
    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_eff
            assign w_okEff[k]   = r_v[k] & (r_ok[k] | sb.res_valid[k]);
            assign w_dataEff[k] = (r_v[k] & sb.res_valid[k]) ?
                                  sb.res_data[k*WIDTH +: WIDTH] : r_data[k];
        end
    endgenerate

    // Youngest matching producer wins; older matches are shadowed.
    always_comb begin
        w_stall  = 1'b0;
        w_rdData = sb.rf_data;
        w_rdHit  = '0;
        w_found  = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int k = 0; k < STAGES; k++) begin
                if (!w_found[p] && r_v[k] &&
                    (r_dst[k] == sb.rd_addr[p*5 +: 5]) &&
                    (sb.rd_addr[p*5 +: 5] != 5'd0)) begin
                    w_found[p] = 1'b1;
                    if (w_okEff[k]) begin
                        w_rdData[p*WIDTH +: WIDTH] = w_dataEff[k];
                        w_rdHit[p]                 = 1'b1;
                    end else if (r_tnew[k] > sb.rd_tuse[p*TW +: TW]) begin
                        w_stall = 1'b1;
                    end
                end
            end
        end
    end

    assign w_accept   = sb.issue_valid & ~w_stall;
    assign sb.rd_data = w_rdData;
    assign sb.rd_hit  = w_rdHit;
    assign sb.stall   = w_stall;

    // Entries shift every cycle, stalled or not; a stall only inserts a bubble.
    always_ff @(posedge clk) begin
        if (reset || sb.flush) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k]    <= 1'b0;
                r_ok[k]   <= 1'b0;
                r_dst[k]  <= '0;
                r_tnew[k] <= '0;
                r_data[k] <= '0;
            end
        end else begin
            r_v[0]    <= w_accept;
            r_ok[0]   <= 1'b0;
            r_dst[0]  <= w_accept ? sb.issue_dst : 5'd0;
            r_tnew[0] <= w_accept ? satDec(sb.issue_tnew) : '0;
            r_data[0] <= '0;
            for (int k = 1; k < STAGES; k++) begin
                r_v[k]    <= r_v[k-1];
                r_ok[k]   <= w_okEff[k-1];
                r_dst[k]  <= r_dst[k-1];
                r_tnew[k] <= satDec(r_tnew[k-1]);
                r_data[k] <= w_dataEff[k-1];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
// ============================================================================
//  Module      : tb_fwd_scoreboard
//  Description : Scoreboard bench for fwd_scoreboard with directed and random
//                traffic against an in-flight-instruction reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwd_scoreboard;

    localparam int W  = 32;
    localparam int ST = 3;
    localparam int NP = 2;
    localparam int TW = 2;

    typedef struct {
        int           issueCyc;
        logic [4:0]   dst;
        int           tnew;
        bit           known;
        logic [W-1:0] data;
    } rec_t;

    typedef struct {
        bit              chk;
        int              cyc;
        logic [NP*W-1:0] data;
        logic [NP-1:0]   hit;
        logic            stall;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   tests;
    int   fails;
    rec_t inflight[$];
    exp_t expQ[$];
    exp_t m;

    fwd_scoreboard_if #(.WIDTH(W), .STAGES(ST), .NRD(NP), .TW(TW)) bus ();

    fwd_scoreboard #(.WIDTH(W), .STAGES(ST), .NRD(NP), .TW(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus; the model predicts outputs, then advances its
    // in-flight list by issue cycle number rather than by pipeline slot.
    task automatic step(input bit rs, input bit fl, input bit iv,
                        input logic [4:0] idst, input int itnew,
                        input logic [ST-1:0] rv, input logic [ST*W-1:0] rdat,
                        input logic [NP*5-1:0] ra, input logic [NP*TW-1:0] rt,
                        input logic [NP*W-1:0] rf, input bit chk);
        exp_t e;
        rec_t r;
        int best, st, rem, tu;
        logic [4:0] a;
        reset           = rs;
        bus.flush       = fl;
        bus.issue_valid = iv;
        bus.issue_dst   = idst;
        bus.issue_tnew  = itnew[TW-1:0];
        bus.res_valid   = rv;
        bus.res_data    = rdat;
        bus.rd_addr     = ra;
        bus.rd_tuse     = rt;
        bus.rf_data     = rf;
        e.chk = chk; e.cyc = cyc; e.data = rf; e.hit = '0; e.stall = 1'b0;
        for (int p = 0; p < NP; p++) begin
            a    = ra[p*5 +: 5];
            tu   = int'(rt[p*TW +: TW]);
            best = -1;
            for (int i = 0; i < inflight.size(); i++) begin
                st = cyc - inflight[i].issueCyc - 1;
                if (a != 5'd0 && inflight[i].dst == a && st >= 0 && st < ST)
                    if (best < 0 || inflight[i].issueCyc > inflight[best].issueCyc)
                        best = i;
            end
            if (best >= 0) begin
                st = cyc - inflight[best].issueCyc - 1;
                if (inflight[best].known || rv[st]) begin
                    e.hit[p] = 1'b1;
                    e.data[p*W +: W] = rv[st] ? rdat[st*W +: W] : inflight[best].data;
                end else begin
                    rem = inflight[best].tnew - (cyc - inflight[best].issueCyc);
                    if (rem < 0) rem = 0;
                    if (rem > tu) e.stall = 1'b1;
                end
            end
        end
        expQ.push_back(e);
        for (int i = 0; i < inflight.size(); i++) begin
            st = cyc - inflight[i].issueCyc - 1;
            if (st >= 0 && st < ST && rv[st]) begin
                inflight[i].known = 1'b1;
                inflight[i].data  = rdat[st*W +: W];
            end
        end
        if (rs || fl) begin
            inflight.delete();
        end else if (iv && !e.stall) begin
            r.issueCyc = cyc; r.dst = idst; r.tnew = itnew; r.known = 1'b0; r.data = '0;
            inflight.push_back(r);
        end
        for (int i = inflight.size() - 1; i >= 0; i--)
            if (cyc - inflight[i].issueCyc >= ST) inflight.delete(i);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input logic [NP*5-1:0] ra, input logic [NP*TW-1:0] rt,
                        input logic [ST-1:0] rv, input logic [ST*W-1:0] rdat);
        step(0, 0, 0, 5'd0, 0, rv, rdat, ra, rt, {32'h0000_2222, 32'h0000_1111}, 1);
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            m = expQ.pop_front();
            if (m.chk) begin
                tests++;
                if (bus.rd_data !== m.data) begin
                    fails++;
                    $display("FAIL rd_data cyc=%0d got %h want %h", m.cyc, bus.rd_data, m.data);
                end
                tests++;
                if (bus.rd_hit !== m.hit) begin
                    fails++;
                    $display("FAIL rd_hit cyc=%0d got %b want %b", m.cyc, bus.rd_hit, m.hit);
                end
                tests++;
                if (bus.stall !== m.stall) begin
                    fails++;
                    $display("FAIL stall cyc=%0d got %b want %b", m.cyc, bus.stall, m.stall);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got timeout want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ST*W-1:0] rdat;
        logic [NP*5-1:0] ra;
        logic [NP*TW-1:0] rt;
        logic [NP*W-1:0] rf;
        tests = 0; fails = 0; cyc = 0;
        reset = 1'b1;
        bus.flush = 0; bus.issue_valid = 0; bus.issue_dst = '0; bus.issue_tnew = '0;
        bus.res_valid = '0; bus.res_data = '0; bus.rd_addr = '0; bus.rd_tuse = '0;
        bus.rf_data = '0;
        @(posedge clk); #1;

        // Reset: registers are unknown before the first edge
        step(1, 0, 0, 5'd0, 0, '0, '0, {5'd3, 5'd5}, '0, {32'h22, 32'h11}, 0);
        step(1, 0, 0, 5'd0, 0, '0, '0, {5'd3, 5'd5}, '0, {32'h22, 32'h11}, 1);
        step(0, 0, 0, 5'd0, 0, '0, '0, {5'd3, 5'd5}, '0, {32'h22, 32'h11}, 1);

        // E->D forward then carried through M and W
        step(0, 0, 1, 5'd8, 1, '0, '0, '0, '0, {32'h22, 32'h11}, 1);
        idle({5'd0, 5'd8}, '0, 3'b001, {64'h0, 32'h0000_1234});
        idle({5'd8, 5'd8}, '0, '0, '0);
        idle({5'd0, 5'd8}, '0, '0, '0);
        idle('0, '0, '0, '0);

        // Load-use stall, resolved by M-stage result
        step(0, 0, 1, 5'd9, 2, '0, '0, '0, '0, {32'h22, 32'h11}, 1);
        step(0, 0, 1, 5'd7, 1, '0, '0, {5'd0, 5'd9}, '0, {32'h22, 32'h11}, 1);
        idle({5'd0, 5'd9}, '0, 3'b010, {32'h0, 32'h0000_CAFE, 32'h0});
        idle('0, '0, '0, '0);
        idle('0, '0, '0, '0);

        // Youngest match wins, both ready
        step(0, 0, 1, 5'd4, 1, '0, '0, '0, '0, {32'h22, 32'h11}, 1);
        idle('0, '0, 3'b001, {64'h0, 32'h0000_AAAA});
        step(0, 0, 1, 5'd4, 1, '0, '0, '0, '0, {32'h22, 32'h11}, 1);
        idle({5'd4, 5'd4}, '0, 3'b001, {64'h0, 32'h0000_BBBB});
        idle('0, '0, '0, '0);
        idle('0, '0, '0, '0);

        // Youngest match not ready: stall, older ready copy ignored
        step(0, 0, 1, 5'd4, 1, '0, '0, '0, '0, {32'h22, 32'h11}, 1);
        idle('0, '0, 3'b001, {64'h0, 32'h0000_AAAA});
        step(0, 0, 1, 5'd4, 2, '0, '0, '0, '0, {32'h22, 32'h11}, 1);
        idle({5'd0, 5'd4}, '0, '0, '0);
        idle('0, '0, '0, '0);
        idle('0, '0, '0, '0);

        // $zero never forwards
        step(0, 0, 1, 5'd0, 1, '0, '0, '0, '0, {32'h22, 32'h11}, 1);
        idle({5'd0, 5'd0}, '0, 3'b001, {64'h0, 32'h0000_5555});
        idle('0, '0, '0, '0);
        idle('0, '0, '0, '0);

        // Flush mid-stall
        step(0, 0, 1, 5'd9, 2, '0, '0, '0, '0, {32'h22, 32'h11}, 1);
        step(0, 1, 1, 5'd9, 1, '0, '0, {5'd0, 5'd9}, '0, {32'h22, 32'h11}, 1);
        idle({5'd9, 5'd9}, '0, 3'b111, {32'h1, 32'h2, 32'h3});
        idle({5'd9, 5'd9}, '0, '0, '0);

        // Randomized traffic over a small register set to force collisions
        for (int n = 0; n < 1500; n++) begin
            rdat = {$urandom(), $urandom(), $urandom()};
            ra   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            rt   = 4'($urandom_range(0, 15));
            rf   = {$urandom(), $urandom()};
            step($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 rdat, ra, rt, rf, 1);
        end

        @(negedge clk); #1;
        tests++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending want 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and stall unit for the pipelined MIPS core. It replaces the fixed per-operand forwarding multiplexers with one tracker. That tracker holds every in-flight register write for STAGES pipeline stages after decode, supplies forwarded operands for NRD decode-stage read ports, and raises a stall when a producer's result cannot arrive before the consumer's Tuse. It sits beside the decode stage, and the E/M/W stages report their results into it.

## Interface
- WIDTH, 32, datapath width
- STAGES, 3, in-flight stages tracked after decode (entry 0 = E, 1 = M, 2 = W)
- NRD, 2, number of decode read ports (rs, rt)
- TW, 2, width of Tnew/Tuse fields; must satisfy 2^TW > STAGES

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous clear of all entries
- issue_valid  in  1  decode instruction writes a register
- issue_dst  in  5  destination register
- issue_tnew  in  TW  cycles until the result exists, counted from entry into entry 0
- res_valid  in  STAGES  bit k: stage k produces its entry's result this cycle
- res_data  in  STAGES*WIDTH  slice k is the result from stage k
- rd_addr  in  NRD*5  slice p is the register read by port p
- rd_tuse  in  NRD*TW  slice p is the cycles until port p needs the value
- rf_data  in  NRD*WIDTH  slice p is the register-file read value
- rd_data  out  NRD*WIDTH  slice p is the operand after forwarding
- rd_hit  out  NRD  bit p: rd_data[p] was forwarded
- stall  out  1  decode must hold; a bubble enters entry 0

## Operation
- Each entry k holds: v, dst[4:0], tnew[TW-1:0], ok, data[WIDTH-1:0].
- Effective values in the current cycle:
  - ok_eff[k] = ok[k] | res_valid[k]
  - data_eff[k] = res_valid[k] ? res_data slice k : data[k]
- Lookup for each port p, with a = rd_addr[p]:
  - Scan k = 0..STAGES-1 (youngest first) for the first entry with v & dst==a.
  - a==0 never matches.
  - Only the youngest match is used; older matches are ignored.
- Port p result:
  - If a match exists and ok_eff: rd_data = data_eff, rd_hit = 1.
  - If a match exists and !ok_eff and tnew > rd_tuse[p]: stall_p = 1, rd_data = rf_data, rd_hit = 0.
  - Otherwise: rd_data = rf_data, rd_hit = 0.
- stall = OR of all stall_p. It is combinational and does not depend on issue_valid.
- Update at every clk edge:
  - For k ≥ 1: entry k ← entry k-1, with ok ← ok_eff[k-1], data ← data_eff[k-1], tnew ← sat_dec(tnew[k-1]).
  - Entry 0 ← issue fields, with ok = 0 and tnew = sat_dec(issue_tnew), when issue_valid & !stall.
  - Otherwise entry 0 ← bubble (v = 0).
  - The oldest entry is dropped each cycle; its write reaches the register file outside this block.
- sat_dec(x) = (x==0) ? 0 : x-1.
- res_valid[k] with v[k]=0 is ignored: no stored state changes and nothing is forwarded.
- issue_dst==0 is accepted into the entry but never matches.
- Priority: reset, then flush, then normal update.
  - Both reset and flush clear all v, ok, dst, tnew and data to 0.
  - Any stall and issue in that same cycle are discarded.

## Timing
- Reset values: all entries cleared. Outputs follow: rd_hit = 0, stall = 0, rd_data = rf_data.
- rd_data, rd_hit and stall are combinational from the inputs and the entry registers. Zero-cycle forwarding: a result presented on res_valid[k] is forwarded in the same cycle.
- Stall is one decision per cycle. Entries advance even while stalled, so a stalled producer moves one stage closer each cycle.
- A producer issued at cycle n with issue_tnew = T has forwarded data available no later than cycle n+T, provided the stage pipeline asserts res_valid on time.
- Data captured via res_valid travels with its entry until it leaves stage STAGES-1.
- Reset or flush asserted mid-stall clears stall in the following cycle.

## Test plan
- Reset: hold reset 2 cycles with rd_addr={5,3} and rf_data={0x11,0x22} → rd_data={0x11,0x22}, rd_hit=0, stall=0.
- E→D forward (ALU): issue dst=8, tnew=1 at cycle 0. In cycle 1 assert res_valid[0] with data 0x1234 and rd_addr[0]=8, tuse=0 → rd_data[0]=0x1234, rd_hit[0]=1, stall=0. In cycles 2 and 3 the same value is still forwarded from entries 1 and 2.
- Load-use stall: issue dst=9, tnew=2. The next cycle reads rs=9 with tuse=0 → stall=1 for exactly 1 cycle. The following cycle, res_valid[1]=1 with 0xCAFE → rd_data=0xCAFE, stall=0.
- Youngest match wins: r4 is present in entry 2 with data 0xAAAA and in entry 0 with data 0xBBBB, both ok → rd_data=0xBBBB. If entry 0 is not ok and tnew=1 > tuse=0 → stall=1, and the 0xAAAA entry is ignored.
- $zero: issue dst=0 with res_valid, then read r0 → rd_hit=0, rd_data=rf_data, stall=0.
- Flush mid-stall: create the load-use stall, then assert flush → the next cycle has stall=0, rd_hit=0, and all entries are empty.
